// File: rtl/meta_discard_dispatch_pkg.sv
// meta_discard_dispatch_pkg: metadata field offsets and dispatch FSM encoding
package meta_discard_dispatch_pkg;
  localparam int META_DISCARD_POS = 128;
  localparam int META_DPORT_HI = 31;
  localparam int META_DPORT_LO = 24;
  localparam int META_NTID_HI = 355;
  localparam int META_NTID_LO = 350;
  typedef enum logic [2:0] {
    IDLE_S,
    DECIDE_S,
    FWD_FIRST_S,
    FWD_BODY_S,
    DROP_S
  } state_t;
endpackage

// File: rtl/meta_discard_dispatch_fifo.sv
// meta_sync_fifo: single-clock FIFO; a push into a full FIFO is accepted when a pop happens the same cycle
module meta_sync_fifo #(
  parameter int W = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  assign full = count == (AW+1)'(2**AW);
  assign empty = count == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = mem[rd_ptr];
  // storage write; contents need no reset since count gates every read
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  // pointers wrap naturally at 2^AW; count disambiguates full from empty
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/meta_discard_dispatch.sv
// meta_discard_dispatch: pairs metadata with packets, drops or forwards with rewritten first-beat tuser; DISPATCH_DROP_PORT0_EN also drops dst_port 0
module meta_discard_dispatch
  import meta_discard_dispatch_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int META_LEN = 256,
  parameter int COMP_LEN = 100,
  parameter int META_FIFO_AW = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [META_LEN+COMP_LEN-1:0]      comp_meta_data_in,
  input  logic                              comp_meta_data_valid_in,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic [15:0]                       meta_ovf_cnt,
  output logic [31:0]                       pkt_fwd_cnt,
  output logic [31:0]                       pkt_drop_cnt
);
  localparam int MW = META_DISCARD_POS + 1;
  state_t state;
  logic [MW-1:0] meta_r, head;
  logic full, empty, fwd, pop, ovf, drop_dec, unused_meta;
  logic [META_FIFO_AW:0] fifo_count_unused;
  assign unused_meta = ^comp_meta_data_in[META_LEN+COMP_LEN-1:MW];
  meta_sync_fifo #(.W(MW), .AW(META_FIFO_AW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(comp_meta_data_valid_in),
    .pop(pop),
    .din(comp_meta_data_in[MW-1:0]),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count_unused)
  );
`ifdef DISPATCH_DROP_PORT0_EN
  assign drop_dec = meta_r[META_DISCARD_POS] | (meta_r[META_DPORT_HI:META_DPORT_LO] == 8'h00);
`else
  assign drop_dec = meta_r[META_DISCARD_POS];
`endif
  // zero-cycle stream path steered by state; first beat carries the updated NetFPGA metadata
  always_comb begin
    fwd = (state == FWD_FIRST_S) || (state == FWD_BODY_S);
    s_axis_tready = fwd ? m_axis_tready : (state == DROP_S);
    m_axis_tvalid = fwd & s_axis_tvalid;
    m_axis_tlast = fwd & s_axis_tlast;
    m_axis_tdata = fwd ? s_axis_tdata : '0;
    m_axis_tkeep = fwd ? s_axis_tkeep : '0;
    m_axis_tuser = (state == FWD_FIRST_S) ? meta_r[C_S_AXIS_TUSER_WIDTH-1:0] : fwd ? s_axis_tuser : '0;
    pop = s_axis_tvalid & s_axis_tready & s_axis_tlast;
    ovf = comp_meta_data_valid_in & full & ~pop;
  end
  // pairing FSM plus packet and overflow statistics
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE_S;
      meta_r <= '0;
      meta_ovf_cnt <= '0;
      pkt_fwd_cnt <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      case (state)
        IDLE_S: if (!empty) begin
          meta_r <= head;
          state <= DECIDE_S;
        end
        DECIDE_S: state <= drop_dec ? DROP_S : FWD_FIRST_S;
        FWD_FIRST_S: if (s_axis_tvalid && s_axis_tready) state <= s_axis_tlast ? IDLE_S : FWD_BODY_S;
        FWD_BODY_S, DROP_S: if (pop) state <= IDLE_S;
        default: state <= IDLE_S;
      endcase
      if (pop && state == DROP_S) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
      if (pop && fwd) pkt_fwd_cnt <= pkt_fwd_cnt + 32'd1;
      if (ovf && meta_ovf_cnt != 16'hFFFF) meta_ovf_cnt <= meta_ovf_cnt + 16'd1;
    end
endmodule

// File: tb/tb_meta_discard_dispatch.sv
// tb_meta_discard_dispatch: randomized self-checking bench with a queue-based pairing model
module tb_meta_discard_dispatch;
  localparam int DW = 256;
  localparam int KW = 32;
  localparam int UW = 128;
  localparam int MLEN = 356;
`ifdef DISPATCH_DROP_PORT0_EN
  localparam bit PORT0_DROP = 1'b1;
`else
  localparam bit PORT0_DROP = 1'b0;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic [MLEN-1:0] comp_meta_data_in = '0;
  logic comp_meta_data_valid_in = 0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic [UW-1:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 0;
  logic s_axis_tlast = 0;
  logic s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tready = 1;
  logic [15:0] meta_ovf_cnt;
  logic [31:0] pkt_fwd_cnt;
  logic [31:0] pkt_drop_cnt;
  meta_discard_dispatch dut (
    .clk(clk),
    .rst_n(rst_n),
    .comp_meta_data_in(comp_meta_data_in),
    .comp_meta_data_valid_in(comp_meta_data_valid_in),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .meta_ovf_cnt(meta_ovf_cnt),
    .pkt_fwd_cnt(pkt_fwd_cnt),
    .pkt_drop_cnt(pkt_drop_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int exp_ovf = 0;
  logic [DW-1:0] obs_data[$];
  logic [KW-1:0] obs_keep[$];
  logic [UW-1:0] obs_user[$];
  logic obs_last[$];
  int vld_cycles, mirror_err, timed_out;
  logic [31:0] pkt_seed;
  bit toggle_rdy = 0;
  bit rand_rdy = 0;
  logic [MLEN-1:0] q_meta[$];
  function automatic logic [MLEN-1:0] make_meta(input logic disc, input logic [7:0] dp);
    logic [MLEN-1:0] m;
    m = '0;
    for (int i = 0; i < 11; i++) m[i*32 +: 32] = $urandom;
    m[355:352] = 4'($urandom);
    m[128] = disc;
    m[31:24] = dp;
    return m;
  endfunction
  function automatic logic [DW-1:0] beat_data(input logic [31:0] s, input int b);
    return {8{s ^ 32'(b)}};
  endfunction
  function automatic logic [KW-1:0] beat_keep(input logic [31:0] s, input int b);
    return ~s ^ 32'(b);
  endfunction
  task automatic push_meta(input logic [MLEN-1:0] m);
    @(negedge clk);
    comp_meta_data_in = m;
    comp_meta_data_valid_in = 1;
    @(negedge clk);
    comp_meta_data_valid_in = 0;
  endtask
  task automatic push_burst(input int n, input int first_port);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      comp_meta_data_in = make_meta(1'b0, 8'(first_port + k));
      comp_meta_data_valid_in = 1;
    end
    @(negedge clk);
    comp_meta_data_valid_in = 0;
  endtask
  task automatic send_pkt(input int n, input logic [UW-1:0] tu, input logic strobe, input logic [MLEN-1:0] sm);
    int b = 0;
    int t = 0;
    obs_data.delete();
    obs_keep.delete();
    obs_user.delete();
    obs_last.delete();
    vld_cycles = 0;
    mirror_err = 0;
    timed_out = 0;
    pkt_seed = $urandom;
    while (b < n && t < 300) begin
      @(negedge clk);
      s_axis_tvalid = 1;
      s_axis_tdata = beat_data(pkt_seed, b);
      s_axis_tkeep = beat_keep(pkt_seed, b);
      s_axis_tuser = tu;
      s_axis_tlast = (b == n - 1);
      comp_meta_data_in = sm;
      comp_meta_data_valid_in = strobe && t == 0;
      if (toggle_rdy) m_axis_tready = ~m_axis_tready;
      else if (rand_rdy) m_axis_tready = ($urandom_range(3) != 0);
      #1;
      if (m_axis_tvalid) begin
        vld_cycles++;
        if (s_axis_tready !== m_axis_tready) mirror_err++;
        if (m_axis_tready) begin
          obs_data.push_back(m_axis_tdata);
          obs_keep.push_back(m_axis_tkeep);
          obs_user.push_back(m_axis_tuser);
          obs_last.push_back(m_axis_tlast);
        end
      end
      if (s_axis_tready) b++;
      t++;
    end
    @(negedge clk);
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    comp_meta_data_valid_in = 0;
    m_axis_tready = 1;
    if (b < n) timed_out = 1;
  endtask
  task automatic test_reset();
    rst_n = 0;
    s_axis_tvalid = 1;
    s_axis_tdata = {8{$urandom}};
    s_axis_tlast = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: tready=%b tvalid=%b tlast=%b, expected all 0", s_axis_tready, m_axis_tvalid, m_axis_tlast);
    end
    checks++;
    if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
      failures++;
      $display("FAIL reset_data: tdata=%h tkeep=%h tuser=%h, expected 0", m_axis_tdata, m_axis_tkeep, m_axis_tuser);
    end
    checks++;
    if (meta_ovf_cnt !== 16'd0 || pkt_fwd_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: ovf=%0d fwd=%0d drop=%0d, expected 0", meta_ovf_cnt, pkt_fwd_cnt, pkt_drop_cnt);
    end
    s_axis_tvalid = 0;
    s_axis_tlast = 0;
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic test_forward();
    logic [MLEN-1:0] m;
    m = make_meta(1'b0, 8'h04);
    push_meta(m);
    send_pkt(3, '0, 1'b0, '0);
    exp_fwd++;
    checks++;
    if (timed_out !== 0 || obs_data.size() !== 3) begin
      failures++;
      $display("FAIL fwd_beats: got %0d beats timeout=%0d, expected 3", obs_data.size(), timed_out);
    end else begin
      checks++;
      if (obs_user[0][31:24] !== 8'h04 || obs_user[0] !== m[127:0]) begin
        failures++;
        $display("FAIL fwd_first_tuser: got %h, expected %h", obs_user[0], m[127:0]);
      end
      for (int b = 0; b < 3; b++) begin
        checks++;
        if (obs_data[b] !== beat_data(pkt_seed, b) || obs_keep[b] !== beat_keep(pkt_seed, b) || obs_last[b] !== (b == 2) || (b > 0 && obs_user[b] !== '0)) begin
          failures++;
          $display("FAIL fwd_beat%0d: data=%h keep=%h last=%b user=%h, expected data=%h keep=%h last=%b", b, obs_data[b], obs_keep[b], obs_last[b], obs_user[b], beat_data(pkt_seed, b), beat_keep(pkt_seed, b), b == 2);
        end
      end
    end
    checks++;
    if (pkt_fwd_cnt !== 32'(exp_fwd)) begin
      failures++;
      $display("FAIL fwd_count: got %0d, expected %0d", pkt_fwd_cnt, exp_fwd);
    end
  endtask
  task automatic test_drop();
    push_meta(make_meta(1'b1, 8'h07));
    send_pkt(2, {4{$urandom}}, 1'b0, '0);
    exp_drop++;
    checks++;
    if (timed_out !== 0 || vld_cycles !== 0) begin
      failures++;
      $display("FAIL drop_stream: timeout=%0d m_tvalid_cycles=%0d, expected 0 and 0", timed_out, vld_cycles);
    end
    checks++;
    if (pkt_drop_cnt !== 32'(exp_drop) || pkt_fwd_cnt !== 32'(exp_fwd)) begin
      failures++;
      $display("FAIL drop_count: drop=%0d fwd=%0d, expected %0d and %0d", pkt_drop_cnt, pkt_fwd_cnt, exp_drop, exp_fwd);
    end
  endtask
  task automatic test_overflow();
    push_burst(5, 1);
    exp_ovf++;
    repeat (3) @(negedge clk);
    checks++;
    if (meta_ovf_cnt !== 16'(exp_ovf)) begin
      failures++;
      $display("FAIL ovf_count: got %0d, expected %0d", meta_ovf_cnt, exp_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      send_pkt(1, {4{$urandom}}, 1'b0, '0);
      exp_fwd++;
      checks++;
      if (timed_out !== 0 || obs_user.size() !== 1 || obs_user[0][31:24] !== 8'(k + 1)) begin
        failures++;
        $display("FAIL ovf_order%0d: beats=%0d dst=%h, expected 1 beat dst=%0d", k, obs_user.size(), obs_user.size() > 0 ? obs_user[0][31:24] : 8'hxx, k + 1);
      end
    end
    checks++;
    if (pkt_fwd_cnt !== 32'(exp_fwd)) begin
      failures++;
      $display("FAIL ovf_fwd_count: got %0d, expected %0d", pkt_fwd_cnt, exp_fwd);
    end
  endtask
  task automatic test_push_on_pop();
    push_burst(4, 5);
    repeat (4) @(negedge clk);
    send_pkt(1, {4{$urandom}}, 1'b1, make_meta(1'b0, 8'd9));
    exp_fwd++;
    checks++;
    if (timed_out !== 0 || obs_user.size() !== 1 || obs_user[0][31:24] !== 8'd5) begin
      failures++;
      $display("FAIL pushpop_first: beats=%0d, expected 1 beat dst=5", obs_user.size());
    end
    checks++;
    if (meta_ovf_cnt !== 16'(exp_ovf)) begin
      failures++;
      $display("FAIL pushpop_ovf: got %0d, expected %0d", meta_ovf_cnt, exp_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      send_pkt(1, {4{$urandom}}, 1'b0, '0);
      exp_fwd++;
      checks++;
      if (timed_out !== 0 || obs_user.size() !== 1 || obs_user[0][31:24] !== 8'(k + 6)) begin
        failures++;
        $display("FAIL pushpop_order%0d: beats=%0d, expected 1 beat dst=%0d", k, obs_user.size(), k + 6);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [MLEN-1:0] m;
    logic [UW-1:0] tu;
    m = make_meta(1'b0, 8'h03);
    tu = {4{$urandom}};
    push_meta(m);
    toggle_rdy = 1;
    send_pkt(4, tu, 1'b0, '0);
    toggle_rdy = 0;
    exp_fwd++;
    checks++;
    if (timed_out !== 0 || obs_data.size() !== 4 || mirror_err !== 0) begin
      failures++;
      $display("FAIL toggle_stream: beats=%0d timeout=%0d mirror_err=%0d, expected 4, 0, 0", obs_data.size(), timed_out, mirror_err);
    end else begin
      for (int b = 0; b < 4; b++) begin
        checks++;
        if (obs_data[b] !== beat_data(pkt_seed, b) || obs_last[b] !== (b == 3) || obs_user[b] !== (b == 0 ? m[127:0] : tu)) begin
          failures++;
          $display("FAIL toggle_beat%0d: data=%h last=%b user=%h, expected data=%h", b, obs_data[b], obs_last[b], obs_user[b], beat_data(pkt_seed, b));
        end
      end
    end
  endtask
  task automatic test_port0();
    logic [MLEN-1:0] m;
    int nexp;
    m = make_meta(1'b0, 8'h00);
    push_meta(m);
    send_pkt(2, {4{$urandom}}, 1'b0, '0);
    nexp = PORT0_DROP ? 0 : 2;
    exp_drop += PORT0_DROP ? 1 : 0;
    exp_fwd += PORT0_DROP ? 0 : 1;
    checks++;
    if (timed_out !== 0 || obs_data.size() !== nexp) begin
      failures++;
      $display("FAIL port0_beats: got %0d timeout=%0d, expected %0d", obs_data.size(), timed_out, nexp);
    end
    checks++;
    if (pkt_drop_cnt !== 32'(exp_drop) || pkt_fwd_cnt !== 32'(exp_fwd)) begin
      failures++;
      $display("FAIL port0_count: drop=%0d fwd=%0d, expected %0d and %0d", pkt_drop_cnt, pkt_fwd_cnt, exp_drop, exp_fwd);
    end
  endtask
  task automatic test_random();
    for (int p = 0; p < 24; p++) begin
      int n;
      int nexp;
      logic drop;
      logic [UW-1:0] tu;
      logic [MLEN-1:0] m;
      do begin
        m = make_meta($urandom_range(3) == 0, 8'($urandom_range(3)));
        push_meta(m);
        q_meta.push_back(m);
      end while (q_meta.size() < 4 && $urandom_range(1) == 1);
      n = $urandom_range(1, 4);
      tu = {4{$urandom}};
      rand_rdy = 1;
      send_pkt(n, tu, 1'b0, '0);
      rand_rdy = 0;
      m = q_meta.pop_front();
      drop = m[128] | (PORT0_DROP & (m[31:24] == 8'h00));
      nexp = drop ? 0 : n;
      if (drop) exp_drop++;
      else exp_fwd++;
      checks++;
      if (timed_out !== 0 || obs_data.size() !== nexp) begin
        failures++;
        $display("FAIL rand%0d_beats: got %0d timeout=%0d, expected %0d", p, obs_data.size(), timed_out, nexp);
      end else begin
        for (int b = 0; b < nexp; b++) begin
          checks++;
          if (obs_data[b] !== beat_data(pkt_seed, b) || obs_keep[b] !== beat_keep(pkt_seed, b) || obs_last[b] !== (b == n - 1) || obs_user[b] !== (b == 0 ? m[127:0] : tu)) begin
            failures++;
            $display("FAIL rand%0d_beat%0d: data=%h user=%h last=%b, expected data=%h user=%h", p, b, obs_data[b], obs_user[b], obs_last[b], beat_data(pkt_seed, b), b == 0 ? m[127:0] : tu);
          end
        end
      end
    end
    while (q_meta.size() > 0) void'(q_meta.pop_front());
    checks++;
    if (pkt_fwd_cnt !== 32'(exp_fwd) || pkt_drop_cnt !== 32'(exp_drop) || meta_ovf_cnt !== 16'(exp_ovf)) begin
      failures++;
      $display("FAIL rand_counts: fwd=%0d drop=%0d ovf=%0d, expected %0d %0d %0d", pkt_fwd_cnt, pkt_drop_cnt, meta_ovf_cnt, exp_fwd, exp_drop, exp_ovf);
    end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_overflow();
    test_push_on_pop();
    test_back_to_back();
    test_port0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
